// File: rtl/sc_updown_speedcounter.sv
// ---------------------------------------------------------------------------
// sc_updown_speedcounter
//
// A general-purpose counter whose counting speed is set by a built-in
// prescaler. It counts up or down between zero and a programmable limit. At
// each bound it either wraps or saturates. It also supports a synchronous
// load and a synchronous clear. It sits between the pushbutton/debounce logic
// and the display/control datapath.
//
// Parameters:
//   DATAWIDTH      width of the count register, the limit and the load data
//   PRESCALEWIDTH  width of the prescaler counter and the prescale compare
//
// Ports:
//   SC_upSPEEDCOUNTER_CLOCK_50      system clock, rising edge
//   SC_upSPEEDCOUNTER_RESET_InHigh  asynchronous, active-high reset
//   clear_InHigh      synchronous clear of the count and the prescaler
//   load_InLow        synchronous load strobe, active low
//   load_data_InBUS   value loaded (clamped to the limit)
//   upcount_InLow     count-up request, active low
//   downcount_InLow   count-down request, active low
//   saturate_InHigh   1 = saturate at the bounds, 0 = wrap
//   limit_InBUS       highest count value (modulus - 1)
//   prescale_InBUS    tick period minus one
//   data_OutBUS       current count
//   tick_Out          registered one-cycle pulse per prescaler tick
//   tc_Out            registered one-cycle terminal-count pulse
//   at_zero_Out       count == 0
//   at_limit_Out      count >= limit
// ---------------------------------------------------------------------------
module sc_updown_speedcounter #(
    parameter int DATAWIDTH     = 8,
    parameter int PRESCALEWIDTH = 16
) (
    input  logic                     SC_upSPEEDCOUNTER_CLOCK_50,
    input  logic                     SC_upSPEEDCOUNTER_RESET_InHigh,
    input  logic                     clear_InHigh,
    input  logic                     load_InLow,
    input  logic [DATAWIDTH-1:0]     load_data_InBUS,
    input  logic                     upcount_InLow,
    input  logic                     downcount_InLow,
    input  logic                     saturate_InHigh,
    input  logic [DATAWIDTH-1:0]     limit_InBUS,
    input  logic [PRESCALEWIDTH-1:0] prescale_InBUS,
    output logic [DATAWIDTH-1:0]     data_OutBUS,
    output logic                     tick_Out,
    output logic                     tc_Out,
    output logic                     at_zero_Out,
    output logic                     at_limit_Out
);

    localparam logic [DATAWIDTH-1:0]     DATA_ONE  = DATAWIDTH'(1);
    localparam logic [PRESCALEWIDTH-1:0] PRESC_ONE = PRESCALEWIDTH'(1);

    logic [DATAWIDTH-1:0]     count_q, count_d;
    logic [PRESCALEWIDTH-1:0] presc_q, presc_d;
    logic                     tick_q, tick_d;
    logic                     tc_q, tc_d;

    logic                     tick_int;
    logic                     step_up;
    logic                     step_down;

    // Next-state logic. Within one edge, clear has priority over load, and
    // load has priority over counting. The prescaler uses '>=' rather than
    // '=='. This way, if prescale is lowered below the current prescaler
    // value at runtime, the prescaler rolls over at once instead of running
    // all the way around its full range.
    always_comb begin
        tick_int  = (presc_q >= prescale_InBUS);
        step_up   = !upcount_InLow && downcount_InLow;
        step_down = !downcount_InLow && upcount_InLow;

        presc_d = tick_int ? '0 : presc_q + PRESC_ONE;
        count_d = count_q;
        tick_d  = tick_int;
        tc_d    = 1'b0;

        if (clear_InHigh) begin
            count_d = '0;
            presc_d = '0;
            tick_d  = 1'b0;
        end else if (!load_InLow) begin
            count_d = (load_data_InBUS > limit_InBUS) ? limit_InBUS : load_data_InBUS;
        end else if (tick_int) begin
            if (step_up) begin
                if (count_q >= limit_InBUS) begin
                    count_d = saturate_InHigh ? limit_InBUS : '0;
                    tc_d    = 1'b1;
                end else begin
                    count_d = count_q + DATA_ONE;
                end
            end else if (step_down) begin
                if (count_q == '0) begin
                    count_d = saturate_InHigh ? '0 : limit_InBUS;
                    tc_d    = 1'b1;
                end else if (count_q > limit_InBUS) begin
                    // The limit was lowered under the count at runtime.
                    // Pull the count back inside the range without
                    // signalling a terminal count.
                    count_d = limit_InBUS;
                end else begin
                    count_d = count_q - DATA_ONE;
                end
            end
        end
    end

    // State registers. Reset is asynchronous, so asserting it forces the
    // outputs to zero immediately, without waiting for a clock edge.
    always_ff @(posedge SC_upSPEEDCOUNTER_CLOCK_50 or posedge SC_upSPEEDCOUNTER_RESET_InHigh) begin
        if (SC_upSPEEDCOUNTER_RESET_InHigh) begin
            count_q <= '0;
            presc_q <= '0;
            tick_q  <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            tc_q    <= tc_d;
        end
    end

    assign data_OutBUS  = count_q;
    assign tick_Out     = tick_q;
    assign tc_Out       = tc_q;
    assign at_zero_Out  = (count_q == '0);
    assign at_limit_Out = (count_q >= limit_InBUS);

endmodule

// File: tb/tb_sc_updown_speedcounter.sv
// ---------------------------------------------------------------------------
// tb_sc_updown_speedcounter
//
// Directed bench for sc_updown_speedcounter. It drives the controls between
// clock edges, advances one cycle, and then compares the outputs against
// hand-computed values. The stimulus covers wrap, saturate, the prescaler,
// counting down, load, clear and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_sc_updown_speedcounter;

    localparam int DW = 8;
    localparam int PW = 16;

    logic          clock_50;
    logic          reset;
    logic          clear;
    logic          load_n;
    logic [DW-1:0] load_data;
    logic          up_n;
    logic          down_n;
    logic          saturate;
    logic [DW-1:0] limit;
    logic [PW-1:0] prescale;
    logic [DW-1:0] data_out;
    logic          tick_out;
    logic          tc_out;
    logic          at_zero;
    logic          at_limit;

    int total_checks = 0;
    int bad_checks   = 0;

    sc_updown_speedcounter #(.DATAWIDTH(DW), .PRESCALEWIDTH(PW)) dut (
        .SC_upSPEEDCOUNTER_CLOCK_50     (clock_50),
        .SC_upSPEEDCOUNTER_RESET_InHigh (reset),
        .clear_InHigh                   (clear),
        .load_InLow                     (load_n),
        .load_data_InBUS                (load_data),
        .upcount_InLow                  (up_n),
        .downcount_InLow                (down_n),
        .saturate_InHigh                (saturate),
        .limit_InBUS                    (limit),
        .prescale_InBUS                 (prescale),
        .data_OutBUS                    (data_out),
        .tick_Out                       (tick_out),
        .tc_Out                         (tc_out),
        .at_zero_Out                    (at_zero),
        .at_limit_Out                   (at_limit)
    );

    // 10 ns period clock.
    initial clock_50 = 1'b0;
    always #5 clock_50 = ~clock_50;

    // Counts one comparison and reports it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Sets the synchronous controls, then advances to 1 ns after the next
    // rising edge, so that outputs are sampled away from the edge.
    task automatic applyStimulus(input logic clr, input logic ld_n, input logic [DW-1:0] ld_data,
                                 input logic u_n, input logic d_n);
        clear     = clr;
        load_n    = ld_n;
        load_data = ld_data;
        up_n      = u_n;
        down_n    = d_n;
        @(posedge clock_50);
        #1;
    endtask

    initial begin
        logic [DW-1:0] exp_wrap [8];
        logic [DW-1:0] exp_sat  [7];
        exp_wrap = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1, 8'd2};
        exp_sat  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd5, 8'd5};

        reset     = 1'b1;
        clear     = 1'b0;
        load_n    = 1'b1;
        load_data = '0;
        up_n      = 1'b1;
        down_n    = 1'b1;
        saturate  = 1'b0;
        limit     = 8'd5;
        prescale  = '0;

        // Reset state.
        applyStimulus(1'b0, 1'b1, 8'd0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'd0, 1'b1, 1'b1);
        checkOutput("reset_data", 32'(data_out), 32'd0);
        checkOutput("reset_tick", 32'(tick_out), 32'd0);
        checkOutput("reset_tc", 32'(tc_out), 32'd0);
        checkOutput("reset_at_zero", 32'(at_zero), 32'd1);
        checkOutput("reset_at_limit", 32'(at_limit), 32'd0);
        reset = 1'b0;

        // Wrap mode, counting up with prescale 0.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 8'd0, 1'b0, 1'b1);
            checkOutput("wrap_data", 32'(data_out), 32'(exp_wrap[i]));
            checkOutput("wrap_tc", 32'(tc_out), (i == 5) ? 32'd1 : 32'd0);
            checkOutput("wrap_tick", 32'(tick_out), 32'd1);
        end

        // Saturate mode: the count climbs to the limit and stays there.
        applyStimulus(1'b1, 1'b1, 8'd0, 1'b1, 1'b1);
        checkOutput("clear_data", 32'(data_out), 32'd0);
        checkOutput("clear_tick", 32'(tick_out), 32'd0);
        saturate = 1'b1;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 1'b1, 8'd0, 1'b0, 1'b1);
            checkOutput("sat_data", 32'(data_out), 32'(exp_sat[i]));
            checkOutput("sat_tc", 32'(tc_out), (i >= 5) ? 32'd1 : 32'd0);
        end
        checkOutput("sat_at_limit", 32'(at_limit), 32'd1);
        saturate = 1'b0;

        // Prescale 3: one step every 4 cycles.
        prescale = 16'd3;
        applyStimulus(1'b1, 1'b1, 8'd0, 1'b1, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b0, 1'b1, 8'd0, 1'b0, 1'b1);
            checkOutput("presc_data", 32'(data_out), 32'(i / 4));
            checkOutput("presc_tick", 32'(tick_out), (i % 4 == 0) ? 32'd1 : 32'd0);
        end

        // Counting down in wrap mode: 0 wraps to 5, then 4, then 3.
        prescale = 16'd0;
        applyStimulus(1'b1, 1'b1, 8'd0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'd0, 1'b1, 1'b0);
        checkOutput("down_wrap_data", 32'(data_out), 32'd5);
        checkOutput("down_wrap_tc", 32'(tc_out), 32'd1);
        applyStimulus(1'b0, 1'b1, 8'd0, 1'b1, 1'b0);
        checkOutput("down_data4", 32'(data_out), 32'd4);
        checkOutput("down_tc0", 32'(tc_out), 32'd0);
        applyStimulus(1'b0, 1'b1, 8'd0, 1'b1, 1'b0);
        checkOutput("down_data3", 32'(data_out), 32'd3);

        // Both requests low: the count holds.
        applyStimulus(1'b0, 1'b1, 8'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'd0, 1'b0, 1'b0);
        checkOutput("both_hold_data", 32'(data_out), 32'd3);
        checkOutput("both_hold_tc", 32'(tc_out), 32'd0);

        // Limit lowered below the count: the next down step clamps to the
        // limit with no tc pulse.
        limit = 8'd2;
        #1;
        checkOutput("lowlim_at_limit", 32'(at_limit), 32'd1);
        applyStimulus(1'b0, 1'b1, 8'd0, 1'b1, 1'b0);
        checkOutput("lowlim_data", 32'(data_out), 32'd2);
        checkOutput("lowlim_tc", 32'(tc_out), 32'd0);
        limit = 8'd5;

        // A load above the limit is clamped to the limit; a load within
        // range is taken as-is.
        applyStimulus(1'b0, 1'b0, 8'd200, 1'b1, 1'b1);
        checkOutput("load_clamp_data", 32'(data_out), 32'd5);
        checkOutput("load_clamp_tc", 32'(tc_out), 32'd0);
        applyStimulus(1'b0, 1'b0, 8'd3, 1'b1, 1'b1);
        checkOutput("load_data", 32'(data_out), 32'd3);

        // Clear beats load in the same cycle and restarts the prescaler.
        // Two idle cycles first leave the prescaler partway through its
        // period (P = 2).
        prescale = 16'd3;
        applyStimulus(1'b0, 1'b1, 8'd0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'd0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'd4, 1'b1, 1'b1);
        checkOutput("clr_load_data", 32'(data_out), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0, 1'b1, 8'd0, 1'b0, 1'b1);
            checkOutput("clr_restart_data", 32'(data_out), (i == 4) ? 32'd1 : 32'd0);
            checkOutput("clr_restart_tick", 32'(tick_out), (i == 4) ? 32'd1 : 32'd0);
        end

        // Limit 0: the count stays at 0, and every tick with a step request
        // pulses tc.
        prescale = 16'd0;
        limit    = 8'd0;
        applyStimulus(1'b1, 1'b1, 8'd0, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b1, 8'd0, 1'b0, 1'b1);
            checkOutput("lim0_data", 32'(data_out), 32'd0);
            checkOutput("lim0_tc", 32'(tc_out), 32'd1);
            checkOutput("lim0_at_zero", 32'(at_zero), 32'd1);
            checkOutput("lim0_at_limit", 32'(at_limit), 32'd1);
        end
        limit = 8'd5;

        // Asynchronous reset asserted at data = 3, between clock edges.
        applyStimulus(1'b1, 1'b1, 8'd0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 8'd0, 1'b0, 1'b1);
        end
        checkOutput("pre_reset_data", 32'(data_out), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_data", 32'(data_out), 32'd0);
        checkOutput("async_reset_tick", 32'(tick_out), 32'd0);
        checkOutput("async_reset_tc", 32'(tc_out), 32'd0);
        applyStimulus(1'b0, 1'b1, 8'd0, 1'b0, 1'b1);
        prescale = 16'd3;
        reset    = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0, 1'b1, 8'd0, 1'b0, 1'b1);
            checkOutput("post_reset_data", 32'(data_out), (i == 4) ? 32'd1 : 32'd0);
            checkOutput("post_reset_tick", 32'(tick_out), (i == 4) ? 32'd1 : 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule

// File: doc/sc_updown_speedcounter.md
Name: sc_updown_speedcounter

Overview:
Parametrised successor of the single-direction speed counter. Adds up/down counting, a programmable modulus limit, wrap or saturate mode, synchronous load and clear, and a built-in prescaler that sets count speed without an external clock divider. Sits between the board debounce/pushbutton logic and the display/control datapath as a general-purpose speed-controlled counter.

Parameters:
DATAWIDTH, 8, width of count register, limit and load data.
PRESCALEWIDTH, 16, width of prescaler counter and prescale compare value.

Ports:
SC_upSPEEDCOUNTER_CLOCK_50  in  1  system clock, 50 MHz, rising edge.
SC_upSPEEDCOUNTER_RESET_InHigh  in  1  asynchronous, active-high reset.
clear_InHigh  in  1  synchronous clear of counter and prescaler.
load_InLow  in  1  synchronous load strobe, active low.
load_data_InBUS  in  DATAWIDTH  value written on load.
upcount_InLow  in  1  count-up request, active low.
downcount_InLow  in  1  count-down request, active low.
saturate_InHigh  in  1  1 = saturate at bounds, 0 = wrap.
limit_InBUS  in  DATAWIDTH  maximum count value (modulus - 1).
prescale_InBUS  in  PRESCALEWIDTH  tick period minus 1.
data_OutBUS  out  DATAWIDTH  current count.
tick_Out  out  1  registered one-cycle pulse per prescaler tick.
tc_Out  out  1  registered one-cycle terminal-count pulse.
at_zero_Out  out  1  count == 0.
at_limit_Out  out  1  count >= limit_InBUS.

Behaviour:
- Reset (async, high): count = 0, prescaler = 0, tick_Out = 0, tc_Out = 0. Resetting mid-operation forces these values immediately, independent of the clock.
- Prescaler P: each edge, if P == prescale_InBUS (or P > prescale_InBUS after a runtime change), then P <= 0 and internal tick = 1; otherwise P <= P + 1 and tick = 0. With prescale = 0, tick fires every cycle. Tick period = prescale_InBUS + 1 cycles.
- Priority per edge: clear > load > count.
- clear_InHigh = 1: count <= 0 and P <= 0. tick_Out and tc_Out go to 0 next cycle.
- load_InLow = 0: count <= min(load_data_InBUS, limit_InBUS), regardless of tick. P is unaffected. tc_Out = 0.
- Counting happens only on tick cycles. The direction is decoded from the request pins:
  - up = 0 and down = 1: step up.
  - down = 0 and up = 1: step down.
  - both 0 or both 1: hold.
- Step up:
  - If count >= limit: wrap mode sets count <= 0; saturate mode sets count <= limit. Either way tc pulses.
  - Otherwise count <= count + 1.
- Step down:
  - If count == 0: wrap mode sets count <= limit; saturate mode holds 0. Either way tc pulses.
  - Otherwise count <= count - 1. If count > limit (limit lowered at runtime), count <= limit and tc does not pulse.
- tc_Out is 1 for exactly the cycle after a tick that hit a bound, including a blocked saturate step. Held saturation produces a pulse on each tick.
- tick_Out is the internal tick delayed one register stage.
- Latency: data_OutBUS changes on the edge where the tick or load is sampled, so the new value is visible one cycle after the request cycle. tc_Out and tick_Out are aligned with the data_OutBUS update.
- at_zero_Out and at_limit_Out are combinational from the count register and limit_InBUS. limit = 0 is legal: count stays 0, and every tick with a step request pulses tc.
- All arithmetic is unsigned, DATAWIDTH bits. Comparisons are unsigned. No wrap occurs via natural overflow; bounds come from the limit only.

Test Plan:
1. DATAWIDTH=8, limit=5, prescale=0, wrap, upcount held low -> data 0,1,2,3,4,5,0,1 on consecutive cycles; tc_Out = 1 only in the cycle data returns to 0.
2. Same setup with saturate=1 -> data climbs to 5 and stays; tc_Out = 1 every cycle after reaching 5; at_limit_Out = 1.
3. prescale=3, upcount low -> data increments every 4 cycles; tick_Out pulses once per 4 cycles, aligned with each increment.
4. limit=5, wrap, count=0, downcount low -> data 5,4,3; tc_Out pulses on the 0->5 step. Both up and down low -> data holds.
5. load 200 with limit 5 -> data = 5. Same cycle clear=1 and load=0 -> data = 0 and prescaler restarts (next tick prescale+1 cycles later).
6. Assert reset asynchronously mid-count at data=3, between clock edges -> data_OutBUS = 0, tick_Out = 0 and tc_Out = 0 immediately. After release, counting resumes from 0 with a full prescale period.
